// File: rtl/picmicro_instr_sequencer_pkg.sv
// Shared definitions for the midrange fetch/sequencing engine: Q-phase encoding,
// default vectors and the commit-edge action codes.
package picmicro_instr_sequencer_pkg;

   typedef enum logic [1:0] {
      Q1 = 2'd0,
      Q2 = 2'd1,
      Q3 = 2'd2,
      Q4 = 2'd3
   } q_phase_t;

   localparam int DEFAULT_RESET_VECTOR = 0;
   localparam int DEFAULT_INT_VECTOR   = 4;

   // What the PC does at a commit edge; listed in decreasing priority after ACT_INC.
   typedef enum logic [2:0] {
      ACT_INC    = 3'd0,
      ACT_RETURN = 3'd1,
      ACT_CALL   = 3'd2,
      ACT_GOTO   = 3'd3,
      ACT_PCL    = 3'd4,
      ACT_SKIP   = 3'd5,
      ACT_INT    = 3'd6
   } pc_action_t;

endpackage

// File: rtl/picmicro_call_stack.sv
// Circular hardware call stack: overwrites the oldest entry when full, wraps on
// pop when empty, and records both events in sticky flags.
module picmicro_call_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 13,
   localparam int SP_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [SP_W-1:0]  sp,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
   localparam logic [SP_W:0]   CNT_ONE = (SP_W + 1)'(1);
   localparam logic [SP_W:0]   FULL = (SP_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SP_W:0]    count;
   logic [SP_W-1:0]  sp_dec;

   assign sp_dec   = sp - SP_ONE;
   assign data_out = mem[sp_dec];

   // Contents survive reset; only the pointer, count and flags are cleared.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[sp] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (push) begin
         sp <= sp + SP_ONE;
         if (count == FULL) begin
            overflow <= 1'b1;
         end else begin
            count <= count + CNT_ONE;
         end
      end else if (pop) begin
         sp <= sp_dec;
         if (count == '0) begin
            underflow <= 1'b1;
         end else begin
            count <= count - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/picmicro_instr_sequencer.sv
// Q-phase generator, program counter and redirect/flush control for the
// midrange core; the decoder's control inputs are acted on only at the Q4 edge.
module picmicro_instr_sequencer
   import picmicro_instr_sequencer_pkg::*;
#(
   parameter int PC_WIDTH     = 13,
   parameter int TGT_WIDTH    = 11,
   parameter int STACK_DEPTH  = 8,
   parameter int RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int INT_VECTOR   = DEFAULT_INT_VECTOR,
   localparam int SP_W        = $clog2(STACK_DEPTH),
   localparam int PCLATH_W    = PC_WIDTH - 8
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [1:0]           q_phase,
   output logic                 instr_rd_en,
   output logic [PC_WIDTH-1:0]  pc_out,
   output logic                 flush,
   input  logic                 op_goto,
   input  logic                 op_call,
   input  logic                 op_return,
   input  logic                 op_skip,
   input  logic [TGT_WIDTH-1:0] target,
   input  logic [PCLATH_W-1:0]  pclath_in,
   input  logic                 pcl_wr_en,
   input  logic [7:0]           pcl_in,
   input  logic                 int_req,
   output logic                 int_ack,
   output logic [SP_W-1:0]      stack_ptr,
   output logic                 stack_overflow,
   output logic                 stack_underflow
);

   localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
   localparam logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(RESET_VECTOR);
   localparam logic [PC_WIDTH-1:0] PC_INT   = PC_WIDTH'(INT_VECTOR);

   q_phase_t            q_state, q_next;
   pc_action_t          action;
   logic [PC_WIDTH-1:0] pc, pc_next, pc_inc, branch_target, stack_top;
   logic                flush_next, commit, push, pop;

   assign q_phase     = q_state;
   assign instr_rd_en = (q_state == Q4);
   assign pc_out      = pc;
   assign commit      = (q_state == Q4);
   assign pc_inc      = pc + PC_ONE;
   // GOTO/CALL literals only reach the low TGT_WIDTH bits; PCLATH supplies the page.
   assign branch_target = {pclath_in[PCLATH_W-1:TGT_WIDTH-8], target};
   assign push        = (action == ACT_CALL) || (action == ACT_INT);
   assign pop         = (action == ACT_RETURN);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_state <= Q1;
         pc      <= PC_RESET;
         flush   <= 1'b1;
         int_ack <= 1'b0;
      end else begin
         q_state <= q_next;
         pc      <= pc_next;
         flush   <= flush_next;
         int_ack <= (action == ACT_INT);
      end
   end

   always_comb begin
      q_next = Q1;
      case (q_state)
         Q1:      q_next = Q2;
         Q2:      q_next = Q3;
         Q3:      q_next = Q4;
         default: q_next = Q1;
      endcase
   end

   // A flushed instruction never redirects, so an interrupt waits for the next real one.
   always_comb begin
      action = ACT_INC;
      if (commit && !flush) begin
         if (op_return)      action = ACT_RETURN;
         else if (op_call)   action = ACT_CALL;
         else if (op_goto)   action = ACT_GOTO;
         else if (pcl_wr_en) action = ACT_PCL;
         else if (op_skip)   action = ACT_SKIP;
         else if (int_req)   action = ACT_INT;
      end
   end

   always_comb begin
      pc_next    = pc;
      flush_next = flush;
      if (commit) begin
         flush_next = (action != ACT_INC);
         case (action)
            ACT_RETURN:       pc_next = stack_top;
            ACT_CALL,
            ACT_GOTO:         pc_next = branch_target;
            ACT_PCL:          pc_next = {pclath_in, pcl_in};
            ACT_INT:          pc_next = PC_INT;
            default:          pc_next = pc_inc;
         endcase
      end
   end

   picmicro_call_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_WIDTH)
   ) u_call_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .data_in   (pc),
      .data_out  (stack_top),
      .sp        (stack_ptr),
      .overflow  (stack_overflow),
      .underflow (stack_underflow)
   );

endmodule

// File: tb/tb_picmicro_instr_sequencer.sv
// Directed bench for the instruction sequencer: free-run, branches, call stack
// limits, interrupt entry, priority, PC wrap and mid-instruction reset.
module tb_picmicro_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  q_phase;
   logic        instr_rd_en;
   logic [12:0] pc_out;
   logic        flush;
   logic        op_goto, op_call, op_return, op_skip;
   logic [10:0] target;
   logic [4:0]  pclath_in;
   logic        pcl_wr_en;
   logic [7:0]  pcl_in;
   logic        int_req;
   logic        int_ack;
   logic [2:0]  stack_ptr;
   logic        stack_overflow, stack_underflow;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   picmicro_instr_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .q_phase         (q_phase),
      .instr_rd_en     (instr_rd_en),
      .pc_out          (pc_out),
      .flush           (flush),
      .op_goto         (op_goto),
      .op_call         (op_call),
      .op_return       (op_return),
      .op_skip         (op_skip),
      .target          (target),
      .pclath_in       (pclath_in),
      .pcl_wr_en       (pcl_wr_en),
      .pcl_in          (pcl_in),
      .int_req         (int_req),
      .int_ack         (int_ack),
      .stack_ptr       (stack_ptr),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctrl();
      op_goto   = 1'b0;
      op_call   = 1'b0;
      op_return = 1'b0;
      op_skip   = 1'b0;
      target    = '0;
      pclath_in = '0;
      pcl_wr_en = 1'b0;
      pcl_in    = '0;
      int_req   = 1'b0;
   endtask

   // Called at the Q1 falling edge; returns at the next instruction's Q1 falling edge.
   task automatic step();
      repeat (4) @(negedge clk);
      clear_ctrl();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      clear_ctrl();
      do_reset();

      check("rst_q", q_phase, 0);
      check("rst_pc", pc_out, 13'h0000);
      check("rst_flush", flush, 1);
      check("rst_sp", stack_ptr, 0);
      check("rst_ovf", stack_overflow, 0);
      check("rst_unf", stack_underflow, 0);
      check("rst_ack", int_ack, 0);

      // Free run: three instruction cycles, phase-by-phase.
      for (int c = 0; c < 3; c++) begin
         check("run_pc", pc_out, c);
         check("run_flush", flush, (c == 0) ? 1 : 0);
         for (int k = 0; k < 4; k++) begin
            check("run_q", q_phase, k);
            check("run_rd_en", instr_rd_en, (k == 3) ? 1 : 0);
            @(negedge clk);
         end
      end
      check("run_pc3", pc_out, 13'h0003);

      // GOTO with PCLATH page bits; a GOTO during the flush cycle is ignored.
      op_goto = 1'b1; target = 11'h123; pclath_in = 5'h18;
      step();
      check("goto_pc", pc_out, 13'h1923);
      check("goto_flush", flush, 1);
      op_goto = 1'b1; target = 11'h055;
      step();
      check("goto_ign_pc", pc_out, 13'h1924);
      check("goto_ign_flush", flush, 0);

      // CALL from 0x0040 then RETURN.
      op_goto = 1'b1; target = 11'h03F;
      step();
      step();
      check("pre_call_pc", pc_out, 13'h0040);
      op_call = 1'b1; target = 11'h200;
      step();
      check("call_pc", pc_out, 13'h0200);
      check("call_sp", stack_ptr, 1);
      check("call_flush", flush, 1);
      step();
      step();
      check("callee_pc", pc_out, 13'h0202);
      op_return = 1'b1;
      step();
      check("ret_pc", pc_out, 13'h0040);
      check("ret_sp", stack_ptr, 0);
      check("ret_flush", flush, 1);
      step();
      check("ret_next_pc", pc_out, 13'h0041);

      // Skip discards the fetched instruction.
      op_skip = 1'b1;
      step();
      check("skip_pc", pc_out, 13'h0042);
      check("skip_flush", flush, 1);
      step();
      check("skip_next_pc", pc_out, 13'h0043);
      check("skip_next_flush", flush, 0);

      // RETURN outranks a simultaneous CALL.
      op_call = 1'b1; target = 11'h300;
      step();
      step();
      check("prio_setup_pc", pc_out, 13'h0301);
      op_return = 1'b1; op_call = 1'b1; target = 11'h100;
      step();
      check("prio_pc", pc_out, 13'h0043);
      check("prio_sp", stack_ptr, 0);
      step();

      // PCL write, then PC wrap 0x1FFF -> 0x0000.
      pcl_wr_en = 1'b1; pclath_in = 5'h1F; pcl_in = 8'hFE;
      step();
      check("pcl_pc", pc_out, 13'h1FFE);
      check("pcl_flush", flush, 1);
      step();
      check("wrap_pre_pc", pc_out, 13'h1FFF);
      step();
      check("wrap_pc", pc_out, 13'h0000);
      check("wrap_flush", flush, 0);

      // GOTO outranks PCL write and skip.
      op_goto = 1'b1; target = 11'h010; pcl_wr_en = 1'b1; pcl_in = 8'h80; op_skip = 1'b1;
      step();
      check("prio_goto_pc", pc_out, 13'h0010);
      step();

      // Interrupt held through a flush cycle is taken at the following commit.
      op_goto = 1'b1; target = 11'h050;
      step();
      int_req = 1'b1;
      step();
      check("int_wait_pc", pc_out, 13'h0051);
      check("int_wait_ack", int_ack, 0);
      check("int_wait_sp", stack_ptr, 0);
      int_req = 1'b1;
      repeat (4) @(negedge clk);
      int_req = 1'b0;
      check("int_pc", pc_out, 13'h0004);
      check("int_ack", int_ack, 1);
      check("int_flush", flush, 1);
      check("int_sp", stack_ptr, 1);
      @(negedge clk);
      check("int_ack_pulse", int_ack, 0);
      repeat (3) @(negedge clk);
      check("isr_pc", pc_out, 13'h0005);
      op_return = 1'b1;
      step();
      check("retfie_pc", pc_out, 13'h0051);
      check("retfie_sp", stack_ptr, 0);
      step();

      // Skip outranks a pending interrupt.
      int_req = 1'b1; op_skip = 1'b1;
      step();
      check("skip_int_pc", pc_out, 13'h0053);
      check("skip_int_ack", int_ack, 0);
      step();

      // Stack limits: nine nested CALLs pushing 1..9, then nine RETURNs.
      do_reset();
      step();
      for (int i = 1; i <= 9; i++) begin
         op_call = 1'b1; target = 11'(i);
         step();
         check("nest_sp", stack_ptr, i % 8);
         check("nest_ovf", stack_overflow, (i == 9) ? 1 : 0);
         step();
      end
      for (int j = 0; j < 9; j++) begin
         op_return = 1'b1;
         step();
         check("unwind_pc", pc_out, (j < 8) ? (9 - j) : 9);
         check("unwind_unf", stack_underflow, (j == 8) ? 1 : 0);
         step();
      end
      check("unwind_sp", stack_ptr, 0);
      check("unwind_ovf_sticky", stack_overflow, 1);

      // Reset at Q3 in the middle of a GOTO.
      op_goto = 1'b1; target = 11'h7FF; pclath_in = 5'h1F;
      @(negedge clk);
      @(negedge clk);
      check("mid_q", q_phase, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_ctrl();
      check("mid_rst_q", q_phase, 0);
      check("mid_rst_pc", pc_out, 13'h0000);
      check("mid_rst_flush", flush, 1);
      check("mid_rst_sp", stack_ptr, 0);
      check("mid_rst_ovf", stack_overflow, 0);
      check("mid_rst_unf", stack_underflow, 0);
      step();
      check("post_rst_pc", pc_out, 13'h0001);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
